cfg_stream_loader: RTL and testbench
====================================

Name: cfg_stream_loader

Overview:
Synthesizable, parametrised successor to the file-driven bitstream loader used in the FPGA fabric wrappers. It accepts configuration words over a valid/ready stream and writes each word into the fabric with a one-hot configs_en strobe. It then applies settle gaps, raises ff_en and finally rdy. It sits between any bitstream source (SPI bridge, ROM, testbench driver) and the fpga top-level. It adds framing/length checking, abort and re-configuration, none of which the previous loader had.

Parameters:
WORD_W, 224, configuration word width (width of configs_in)
NUM_WORDS, 245, number of config words; also width of configs_en
PRE_WAIT, 10, idle cycles between start and first word fetch (0 allowed)
POST_WAIT, 10, idle cycles after the last strobe before ff_en (0 allowed)
RDY_DELAY, 10, cycles from ff_en rising to rdy rising (>=1)

Ports:
clock  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin (re)configuration; sampled only in IDLE, DONE or ERROR
abort  in  1  cancel an in-progress load
s_valid  in  1  stream word valid
s_data  in  WORD_W  stream config word
s_last  in  1  marks final word of bitstream
s_ready  out  1  loader accepts word this cycle
configs_in  out  WORD_W  registered word presented to fabric
configs_en  out  NUM_WORDS  one-hot write strobe, else all zero
ff_en  out  1  fabric flip-flop enable
rdy  out  1  fabric configured and running
busy  out  1  high in PRE, FETCH, STROBE, POST, FFWAIT
err  out  1  sticky framing error
word_cnt  out  $clog2(NUM_WORDS+1)  words written so far

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: configs_in, configs_en, ff_en, rdy, busy, err, word_cnt, s_ready. Reset mid-load discards progress.
- All outputs registered except s_ready (= state==FETCH) and busy (decoded from state).
- Cycle 0 = cycle in which start=1 is sampled. Leaving IDLE/DONE/ERROR on start clears ff_en, rdy, err, word_cnt and idx.
- PRE: PRE_WAIT cycles (cycles 1..PRE_WAIT), then FETCH. If PRE_WAIT=0, go to FETCH directly.
- FETCH: s_ready=1. On s_valid&&s_ready the loader checks framing first:
  - s_last && idx!=NUM_WORDS-1, or idx==NUM_WORDS-1 && !s_last -> ERROR. err<=1; word not written; configs_en stays 0.
  - Otherwise configs_in<=s_data, configs_en<=1<<idx -> STROBE.
- STROBE: exactly one cycle with configs_in and the one-hot strobe both valid. At its end configs_en<=0, idx++, word_cnt++. Next state is POST if idx was NUM_WORDS-1, else FETCH.
- Minimum 2 cycles per word. s_valid low in FETCH stalls indefinitely, with no timeout.
- configs_in holds the last written word after STROBE; it is not cleared.
- POST: POST_WAIT cycles, then ff_en<=1 -> FFWAIT.
- FFWAIT: rdy rises exactly RDY_DELAY cycles after ff_en first reads high -> DONE.
- DONE: ff_en=1, rdy=1 held. start -> PRE (reconfiguration; ff_en and rdy drop the next cycle).
- ERROR: err=1, ff_en=0, rdy=0, configs_en=0. Only start or rst leaves it.
- abort=1 in any busy state -> IDLE next cycle: configs_en<=0, ff_en<=0, rdy<=0; err unchanged; word_cnt holds. abort outside busy is ignored.
- abort and start together: abort takes priority when busy; start wins in IDLE/DONE/ERROR.
- start while busy is ignored.
- idx never wraps; it saturates at NUM_WORDS-1 by construction.

Decomposition:
- cfg_loader_pkg: state enum (IDLE, PRE, FETCH, STROBE, POST, FFWAIT, DONE, ERROR), CNT_W = $clog2(NUM_WORDS+1) and a onehot(idx) function.
- One sub-module, cfg_delay_cnt: loadable down-counter with a done flag. It is reused for PRE_WAIT, POST_WAIT and RDY_DELAY; width = $clog2(max delay+1).

Test Plan:
All scenarios use WORD_W=8, NUM_WORDS=4, PRE_WAIT=2, POST_WAIT=2, RDY_DELAY=3.
- Nominal, s_valid always high with data A1,B2,C3,D4 (last on D4): configs_en=0001/0010/0100/1000 in cycles 4/6/8/10, with configs_in=A1/B2/C3/D4 in those cycles; ff_en=1 from cycle 13; rdy=1 from cycle 16; word_cnt=4; err=0.
- Stalled source, s_valid low 5 cycles before word 2: configs_en=0010 occurs 5 cycles later than nominal; no strobe fires while stalled; s_ready high throughout the stall.
- Short bitstream, s_last on word 3: configs_en never shows 0100; err=1, state ERROR, ff_en and rdy stay 0, word_cnt=2. Then start -> err=0 and a full reload succeeds.
- Missing s_last on word 4: err=1, configs_en never 1000, word_cnt=3.
- abort during cycle 7 of nominal: configs_en=0 from cycle 8, busy=0, ff_en never rises. Then start gives a full nominal sequence.
- Reconfigure from DONE via start: ff_en and rdy fall next cycle, and the nominal sequence repeats. Separately, assert rst mid-STROBE: all outputs 0 immediately (async).

Source files
------------

// File: rtl/cfg_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// cfg_stream_loader_pkg
// Shared definitions for the streaming configuration loader:
//   - state_t      : loader FSM states
//   - widthFor()   : bits needed to hold the values 0..maxVal (never below 1)
//   - maxOf3()     : largest of three integers, used to size the delay counter
// No ports; imported by the loader top and its delay counter.
// ---------------------------------------------------------------------------
package cfg_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_FETCH,
        ST_STROBE,
        ST_POST,
        ST_FFWAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    // A zero-width vector is illegal, so a range that only needs the value 0
    // still gets one bit.
    function automatic int widthFor(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cfg_stream_loader_if.sv
// ---------------------------------------------------------------------------
// cfg_stream_loader_if
// Valid/ready stream carrying configuration words into the loader.
//   s_valid : source has a word this cycle
//   s_data  : configuration word (WORD_W bits)
//   s_last  : word is the final one of the bitstream
//   s_ready : loader accepts the word this cycle
// Modports: master (bitstream source), slave (loader).
// ---------------------------------------------------------------------------
interface cfg_stream_loader_if #(
    parameter int WORD_W = 224
);
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/cfg_stream_loader_delay_cnt.sv
// ---------------------------------------------------------------------------
// cfg_delay_cnt
// Loadable down-counter with a done flag. The loader reuses one instance for
// the pre-fetch gap, the post-load gap and the ff_en-to-rdy delay.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   load_i     : load load_val_i this cycle (wins over en_i)
//   load_val_i : value to load (delay length minus one)
//   en_i       : count down by one, stopping at zero
//   done_o     : counter has reached zero
// ---------------------------------------------------------------------------
module cfg_delay_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Loading takes precedence so the FSM can restart a delay on the same
    // cycle an earlier one finishes; counting sticks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// cfg_stream_loader
// Accepts configuration words over a valid/ready stream and writes each one
// into the fabric with a one-hot configs_en strobe. After the last word it
// waits POST_WAIT cycles, raises ff_en, then raises rdy RDY_DELAY cycles
// later. Checks s_last framing against the expected word count, supports
// abort and reconfiguration from DONE or ERROR.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   start_i      : begin (re)configuration from IDLE, DONE or ERROR
//   abort_i      : cancel a load in progress
//   s            : stream slave (s_valid, s_data, s_last in; s_ready out)
//   configs_in_o : registered word presented to the fabric
//   configs_en_o : one-hot write strobe, zero between writes
//   ff_en_o      : fabric flip-flop enable
//   rdy_o        : fabric configured and running
//   busy_o       : load sequence in progress
//   err_o        : sticky framing error
//   word_cnt_o   : words written so far
// ---------------------------------------------------------------------------
module cfg_stream_loader
    import cfg_stream_loader_pkg::*;
#(
    parameter int WORD_W    = 224,
    parameter int NUM_WORDS = 245,
    parameter int PRE_WAIT  = 10,
    parameter int POST_WAIT = 10,
    parameter int RDY_DELAY = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    cfg_stream_loader_if.slave   s,
    output logic [WORD_W-1:0]    configs_in_o,
    output logic [NUM_WORDS-1:0] configs_en_o,
    output logic                 ff_en_o,
    output logic                 rdy_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [widthFor(NUM_WORDS)-1:0] word_cnt_o
);

    localparam int CNT_W = widthFor(NUM_WORDS);
    localparam int IDX_W = widthFor(NUM_WORDS - 1);
    localparam int DLY_W = widthFor(maxOf3(PRE_WAIT, POST_WAIT, RDY_DELAY));

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // The counter is loaded with length-1 because the cycle it reads zero is
    // itself the final cycle of the gap.
    localparam logic [DLY_W-1:0] PRE_LOAD  = DLY_W'((PRE_WAIT  > 0) ? PRE_WAIT  - 1 : 0);
    localparam logic [DLY_W-1:0] POST_LOAD = DLY_W'((POST_WAIT > 0) ? POST_WAIT - 1 : 0);
    localparam logic [DLY_W-1:0] RDY_LOAD  = DLY_W'((RDY_DELAY > 0) ? RDY_DELAY - 1 : 0);

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       wordCnt_q;
    logic [WORD_W-1:0]      configsIn_q;
    logic [NUM_WORDS-1:0]   configsEn_q;
    logic                   ffEn_q;
    logic                   rdy_q;
    logic                   err_q;

    logic                   dlyLoad;
    logic [DLY_W-1:0]       dlyVal;
    logic                   dlyEn;
    logic                   dlyDone;
    logic                   isLastIdx;
    logic                   canStart;
    logic                   busy;

    function automatic logic [NUM_WORDS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_WORDS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign isLastIdx = (idx_q == LAST_IDX);
    assign canStart  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign busy      = (state_q == ST_PRE)  || (state_q == ST_FETCH) || (state_q == ST_STROBE) ||
                       (state_q == ST_POST) || (state_q == ST_FFWAIT);

    // Delay counter control: each gap is armed on the cycle the FSM decides to
    // enter it, so the counter already holds the right value on the first
    // cycle of the gap. A zero POST_WAIT skips straight to the rdy delay.
    always_comb begin
        dlyLoad = 1'b0;
        dlyVal  = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    dlyLoad = 1'b1;
                    dlyVal  = PRE_LOAD;
                end
            end
            ST_STROBE: begin
                if (!abort_i && isLastIdx) begin
                    dlyLoad = 1'b1;
                    dlyVal  = (POST_WAIT > 0) ? POST_LOAD : RDY_LOAD;
                end
            end
            ST_POST: begin
                if (!abort_i && dlyDone) begin
                    dlyLoad = 1'b1;
                    dlyVal  = RDY_LOAD;
                end
            end
            default: begin
                dlyLoad = 1'b0;
            end
        endcase
    end

    assign dlyEn = (state_q == ST_PRE) || (state_q == ST_POST) || (state_q == ST_FFWAIT);

    cfg_delay_cnt #(
        .W (DLY_W)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dlyLoad),
        .load_val_i (dlyVal),
        .en_i       (dlyEn),
        .done_o     (dlyDone)
    );

    // Main loader FSM with all fabric-facing outputs registered. Abort is
    // checked first in every busy state so it beats both start and a pending
    // handshake; err and word_cnt are left alone by abort. Framing is checked
    // before a word is written, so a badly framed word never strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wordCnt_q   <= '0;
            configsIn_q <= '0;
            configsEn_q <= '0;
            ffEn_q      <= 1'b0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (busy && abort_i) begin
            state_q     <= ST_IDLE;
            configsEn_q <= '0;
            ffEn_q      <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        ffEn_q      <= 1'b0;
                        rdy_q       <= 1'b0;
                        err_q       <= 1'b0;
                        wordCnt_q   <= '0;
                        idx_q       <= '0;
                        configsEn_q <= '0;
                        state_q     <= (PRE_WAIT > 0) ? ST_PRE : ST_FETCH;
                    end
                end
                ST_PRE: begin
                    if (dlyDone) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (s.s_valid) begin
                        if (s.s_last != isLastIdx) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERROR;
                        end else begin
                            configsIn_q <= s.s_data;
                            configsEn_q <= onehot(idx_q);
                            state_q     <= ST_STROBE;
                        end
                    end
                end
                ST_STROBE: begin
                    configsEn_q <= '0;
                    wordCnt_q   <= wordCnt_q + 1'b1;
                    if (isLastIdx) begin
                        if (POST_WAIT > 0) begin
                            state_q <= ST_POST;
                        end else begin
                            ffEn_q  <= 1'b1;
                            state_q <= ST_FFWAIT;
                        end
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_POST: begin
                    if (dlyDone) begin
                        ffEn_q  <= 1'b1;
                        state_q <= ST_FFWAIT;
                    end
                end
                ST_FFWAIT: begin
                    if (dlyDone) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.s_ready    = (state_q == ST_FETCH);
    assign busy_o       = busy;
    assign configs_in_o = configsIn_q;
    assign configs_en_o = configsEn_q;
    assign ff_en_o      = ffEn_q;
    assign rdy_o        = rdy_q;
    assign err_o        = err_q;
    assign word_cnt_o   = wordCnt_q;

    // canStart documents which states honour start; it is folded into the
    // case above, so tie it off here to keep it referenced.
    logic unusedCanStart;
    assign unusedCanStart = canStart;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_stream_loader
// Directed bench for cfg_stream_loader with WORD_W=8, NUM_WORDS=4,
// PRE_WAIT=2, POST_WAIT=2, RDY_DELAY=3. Cycle 0 is the cycle in which start
// is sampled; outputs are logged 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_cfg_stream_loader;

    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] configsIn;
    logic [3:0] configsEn;
    logic       ffEn, rdy, busy, err;
    logic [2:0] wordCnt;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] enLog   [0:63];
    logic [7:0] inLog   [0:63];
    logic       ffLog   [0:63];
    logic       rdyLog  [0:63];
    logic       busyLog [0:63];
    logic       errLog  [0:63];
    logic       readyLog[0:63];
    logic [2:0] wcLog   [0:63];
    logic [7:0] words   [0:3];

    always #5 clk = ~clk;

    cfg_stream_loader_if #(.WORD_W(WORD_W)) sIf ();

    cfg_stream_loader #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .PRE_WAIT  (2),
        .POST_WAIT (2),
        .RDY_DELAY (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .abort_i      (abort),
        .s            (sIf.slave),
        .configs_in_o (configsIn),
        .configs_en_o (configsEn),
        .ff_en_o      (ffEn),
        .rdy_o        (rdy),
        .busy_o       (busy),
        .err_o        (err),
        .word_cnt_o   (wordCnt)
    );

    // Runs nCycles cycles starting with start in cycle 0, logging the outputs
    // of each cycle. The source presents words in order, advancing after each
    // handshake; it holds s_valid low for stallLen ready cycles before word
    // stallWord. abort is pulsed in cycle abortCyc.
    task automatic applyStimulus(input logic [3:0] lastMask, input int stallWord,
                                 input int stallLen, input int abortCyc, input int nCycles);
        int   ptr = 0;
        int   stallCnt = 0;
        logic hs = 1'b0;
        for (int c = 0; c < nCycles; c++) begin
            @(posedge clk); #1;
            if (hs) ptr++;
            enLog[c]    = {4'b0, configsEn};
            inLog[c]    = configsIn;
            ffLog[c]    = ffEn;
            rdyLog[c]   = rdy;
            busyLog[c]  = busy;
            errLog[c]   = err;
            readyLog[c] = sIf.s_ready;
            wcLog[c]    = wordCnt;
            start = (c == 0);
            abort = (c == abortCyc);
            if (ptr < NUM_WORDS && !(ptr == stallWord && stallCnt < stallLen)) begin
                sIf.s_valid = 1'b1;
                sIf.s_data  = words[ptr];
                sIf.s_last  = lastMask[ptr];
            end else begin
                sIf.s_valid = 1'b0;
                sIf.s_data  = 8'h00;
                sIf.s_last  = 1'b0;
                if (ptr == stallWord && stallCnt < stallLen && sIf.s_ready) stallCnt++;
            end
            hs = sIf.s_valid && sIf.s_ready;
        end
        start = 1'b0;
        abort = 1'b0;
        sIf.s_valid = 1'b0;
        sIf.s_last  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCompared += 8;
        if (configsIn !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_configs_in got %h want 00", configsIn); end
        if (configsEn !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_configs_en got %b want 0000", configsEn); end
        if (ffEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ff_en got %b want 0", ffEn); end
        if (rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rdy got %b want 0", rdy); end
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err got %b want 0", err); end
        if (wordCnt !== 3'd0) begin nMismatched++; $display("[TB] FAIL reset_word_cnt got %0d want 0", wordCnt); end
        if (sIf.s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_s_ready got %b want 0", sIf.s_ready); end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int strobes = 0;
        logic [7:0] expEn;
        doReset();
        applyStimulus(4'b1000, -1, 0, -1, 20);
        for (int k = 0; k < 4; k++) begin
            expEn = 8'(1 << k);
            nCompared += 2;
            if (enLog[4 + 2 * k] !== expEn) begin nMismatched++; $display("[TB] FAIL nominal_en_c%0d got %b want %b", 4 + 2 * k, enLog[4 + 2 * k], expEn); end
            if (inLog[4 + 2 * k] !== words[k]) begin nMismatched++; $display("[TB] FAIL nominal_in_c%0d got %h want %h", 4 + 2 * k, inLog[4 + 2 * k], words[k]); end
        end
        for (int c = 0; c < 20; c++) if (enLog[c] != 8'h00) strobes++;
        nCompared += 9;
        if (strobes != 4) begin nMismatched++; $display("[TB] FAIL nominal_strobe_count got %0d want 4", strobes); end
        if (busyLog[1] !== 1'b1) begin nMismatched++; $display("[TB] FAIL nominal_busy_c1 got %b want 1", busyLog[1]); end
        if (ffLog[12] !== 1'b0) begin nMismatched++; $display("[TB] FAIL nominal_ff_c12 got %b want 0", ffLog[12]); end
        if (ffLog[13] !== 1'b1) begin nMismatched++; $display("[TB] FAIL nominal_ff_c13 got %b want 1", ffLog[13]); end
        if (rdyLog[15] !== 1'b0) begin nMismatched++; $display("[TB] FAIL nominal_rdy_c15 got %b want 0", rdyLog[15]); end
        if (rdyLog[16] !== 1'b1) begin nMismatched++; $display("[TB] FAIL nominal_rdy_c16 got %b want 1", rdyLog[16]); end
        if (wcLog[19] !== 3'd4) begin nMismatched++; $display("[TB] FAIL nominal_word_cnt got %0d want 4", wcLog[19]); end
        if (errLog[19] !== 1'b0) begin nMismatched++; $display("[TB] FAIL nominal_err got %b want 0", errLog[19]); end
        if (busyLog[19] !== 1'b0) begin nMismatched++; $display("[TB] FAIL nominal_busy_done got %b want 0", busyLog[19]); end
    endtask

    task automatic test_stall();
        int strobes = 0;
        int readyCnt = 0;
        doReset();
        applyStimulus(4'b1000, 1, 5, -1, 25);
        for (int c = 5; c <= 10; c++) if (enLog[c] != 8'h00) strobes++;
        for (int c = 5; c <= 9; c++) if (readyLog[c] === 1'b1) readyCnt++;
        nCompared += 6;
        if (strobes != 0) begin nMismatched++; $display("[TB] FAIL stall_no_strobe got %0d want 0", strobes); end
        if (readyCnt != 5) begin nMismatched++; $display("[TB] FAIL stall_ready_cycles got %0d want 5", readyCnt); end
        if (enLog[11] !== 8'h02) begin nMismatched++; $display("[TB] FAIL stall_en_c11 got %b want 00000010", enLog[11]); end
        if (inLog[11] !== 8'hB2) begin nMismatched++; $display("[TB] FAIL stall_in_c11 got %h want b2", inLog[11]); end
        if (rdyLog[20] !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_rdy_c20 got %b want 0", rdyLog[20]); end
        if (rdyLog[21] !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_rdy_c21 got %b want 1", rdyLog[21]); end
    endtask

    task automatic test_short_bitstream();
        int badEn = 0;
        int ffRdy = 0;
        doReset();
        applyStimulus(4'b0100, -1, 0, -1, 16);
        for (int c = 0; c < 16; c++) begin
            if (enLog[c] == 8'h04) badEn++;
            if (ffLog[c] !== 1'b0 || rdyLog[c] !== 1'b0) ffRdy++;
        end
        nCompared += 6;
        if (badEn != 0) begin nMismatched++; $display("[TB] FAIL short_en0100 got %0d want 0", badEn); end
        if (errLog[8] !== 1'b1) begin nMismatched++; $display("[TB] FAIL short_err got %b want 1", errLog[8]); end
        if (busyLog[8] !== 1'b0) begin nMismatched++; $display("[TB] FAIL short_busy got %b want 0", busyLog[8]); end
        if (ffRdy != 0) begin nMismatched++; $display("[TB] FAIL short_ff_rdy got %0d want 0", ffRdy); end
        if (wcLog[15] !== 3'd2) begin nMismatched++; $display("[TB] FAIL short_word_cnt got %0d want 2", wcLog[15]); end
        if (errLog[15] !== 1'b1) begin nMismatched++; $display("[TB] FAIL short_err_sticky got %b want 1", errLog[15]); end
        applyStimulus(4'b1000, -1, 0, -1, 20);
        nCompared += 4;
        if (errLog[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL short_reload_err got %b want 0", errLog[1]); end
        if (enLog[10] !== 8'h08) begin nMismatched++; $display("[TB] FAIL short_reload_en got %b want 00001000", enLog[10]); end
        if (rdyLog[16] !== 1'b1) begin nMismatched++; $display("[TB] FAIL short_reload_rdy got %b want 1", rdyLog[16]); end
        if (wcLog[19] !== 3'd4) begin nMismatched++; $display("[TB] FAIL short_reload_cnt got %0d want 4", wcLog[19]); end
    endtask

    task automatic test_missing_last();
        int badEn = 0;
        doReset();
        applyStimulus(4'b0000, -1, 0, -1, 16);
        for (int c = 0; c < 16; c++) if (enLog[c] == 8'h08) badEn++;
        nCompared += 4;
        if (enLog[8] !== 8'h04) begin nMismatched++; $display("[TB] FAIL nolast_en_c8 got %b want 00000100", enLog[8]); end
        if (badEn != 0) begin nMismatched++; $display("[TB] FAIL nolast_en1000 got %0d want 0", badEn); end
        if (errLog[10] !== 1'b1) begin nMismatched++; $display("[TB] FAIL nolast_err got %b want 1", errLog[10]); end
        if (wcLog[15] !== 3'd3) begin nMismatched++; $display("[TB] FAIL nolast_word_cnt got %0d want 3", wcLog[15]); end
    endtask

    task automatic test_abort();
        int lateEn = 0;
        int ffHigh = 0;
        doReset();
        applyStimulus(4'b1000, -1, 0, 7, 20);
        for (int c = 8; c < 20; c++) if (enLog[c] != 8'h00) lateEn++;
        for (int c = 0; c < 20; c++) if (ffLog[c] !== 1'b0) ffHigh++;
        nCompared += 6;
        if (busyLog[7] !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_busy_c7 got %b want 1", busyLog[7]); end
        if (busyLog[8] !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy_c8 got %b want 0", busyLog[8]); end
        if (lateEn != 0) begin nMismatched++; $display("[TB] FAIL abort_late_strobe got %0d want 0", lateEn); end
        if (ffHigh != 0) begin nMismatched++; $display("[TB] FAIL abort_ff_en got %0d want 0", ffHigh); end
        if (wcLog[12] !== 3'd2) begin nMismatched++; $display("[TB] FAIL abort_word_cnt got %0d want 2", wcLog[12]); end
        if (errLog[12] !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_err got %b want 0", errLog[12]); end
        applyStimulus(4'b1000, -1, 0, -1, 20);
        nCompared += 4;
        if (wcLog[1] !== 3'd0) begin nMismatched++; $display("[TB] FAIL abort_restart_cnt_clr got %0d want 0", wcLog[1]); end
        if (enLog[4] !== 8'h01) begin nMismatched++; $display("[TB] FAIL abort_restart_en got %b want 00000001", enLog[4]); end
        if (rdyLog[16] !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_restart_rdy got %b want 1", rdyLog[16]); end
        if (wcLog[19] !== 3'd4) begin nMismatched++; $display("[TB] FAIL abort_restart_cnt got %0d want 4", wcLog[19]); end
    endtask

    // Starts from DONE, left behind by the restart at the end of test_abort.
    task automatic test_reconfigure();
        applyStimulus(4'b1000, -1, 0, -1, 20);
        nCompared += 7;
        if (ffLog[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reconf_ff_c0 got %b want 1", ffLog[0]); end
        if (rdyLog[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reconf_rdy_c0 got %b want 1", rdyLog[0]); end
        if (ffLog[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reconf_ff_c1 got %b want 0", ffLog[1]); end
        if (rdyLog[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reconf_rdy_c1 got %b want 0", rdyLog[1]); end
        if (enLog[6] !== 8'h02) begin nMismatched++; $display("[TB] FAIL reconf_en_c6 got %b want 00000010", enLog[6]); end
        if (ffLog[13] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reconf_ff_c13 got %b want 1", ffLog[13]); end
        if (rdyLog[16] !== 1'b1) begin nMismatched++; $display("[TB] FAIL reconf_rdy_c16 got %b want 1", rdyLog[16]); end
    endtask

    // Stops inside the first STROBE cycle and asserts rst without a clock edge.
    task automatic test_reset_mid_strobe();
        applyStimulus(4'b1000, -1, 0, -1, 5);
        nCompared += 1;
        if (enLog[4] !== 8'h01) begin nMismatched++; $display("[TB] FAIL midrst_in_strobe got %b want 00000001", enLog[4]); end
        rst = 1'b1;
        #1;
        nCompared += 8;
        if (configsIn !== 8'h00) begin nMismatched++; $display("[TB] FAIL midrst_configs_in got %h want 00", configsIn); end
        if (configsEn !== 4'b0000) begin nMismatched++; $display("[TB] FAIL midrst_configs_en got %b want 0000", configsEn); end
        if (ffEn !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_ff_en got %b want 0", ffEn); end
        if (rdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_rdy got %b want 0", rdy); end
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_err got %b want 0", err); end
        if (wordCnt !== 3'd0) begin nMismatched++; $display("[TB] FAIL midrst_word_cnt got %0d want 0", wordCnt); end
        if (sIf.s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_s_ready got %b want 0", sIf.s_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        words[0] = 8'hA1;
        words[1] = 8'hB2;
        words[2] = 8'hC3;
        words[3] = 8'hD4;
        sIf.s_valid = 1'b0;
        sIf.s_data  = 8'h00;
        sIf.s_last  = 1'b0;
        #2;
        test_reset();
        test_nominal();
        test_stall();
        test_short_bitstream();
        test_missing_last();
        test_abort();
        test_reconfigure();
        test_reset_mid_strobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
